// File: rtl/seq_link_pkg.sv
// Shared definitions for the serial 1011-framed link (transmitter and detector).
package seq_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } seq_state_e;

  localparam int                    SYNC_W_DEF   = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in/serial-out register: load a word, then shift left one bit per cycle.
module seq_piso #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= {W{1'b0}};
    end else if (i_load) begin
      r_q <= i_din;
    end else if (i_shift) begin
      r_q <= r_q << 1;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/seq_frame_tx_1011.sv
// Serial frame transmitter: SYNC_PAT, payload MSB first, optional parity, idle gap.
// Optional parity bit enabled by defining SEQ_TX_PARITY_EN.
module seq_frame_tx_1011
  import seq_link_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_W     = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = SYNC_PAT_DEF,
  parameter int                GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int              CNT_MAX   = max3(SYNC_W, DATA_W, GAP_CYCLES);
  localparam int              CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // r_state/r_cnt name the line bit that will be driven at the next edge.
  seq_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_bit;
  logic              r_out_valid;
  logic              r_frame_done;

  seq_state_e        w_cur_state;
  seq_state_e        w_nxt_state;
  logic [CNT_W-1:0]  w_cur_cnt;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [SYNC_W-1:0] w_sync_sh;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_bit;
  logic              w_valid;
  logic              w_done;
  logic              w_shift;
  logic              w_msb;

  assign w_in_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept   = in_valid && w_in_ready;

`ifdef SEQ_TX_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^in_data;
    end else begin
      r_par <= r_par;
    end
  end
`endif

  seq_piso #(.W(DATA_W)) u_piso (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_din   (in_data),
    .o_msb   (w_msb)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_bit       = 1'b0;
    w_valid     = 1'b0;
    w_done      = 1'b0;
    w_shift     = 1'b0;
    // An accept starts the first SYNC bit in the same cycle so it lands on the line right after the edge.
    if (w_accept) begin
      w_cur_state = ST_SYNC;
      w_cur_cnt   = {CNT_W{1'b0}};
    end else begin
      w_cur_state = r_state;
      w_cur_cnt   = r_cnt;
    end
    w_sync_sh = SYNC_PAT << w_cur_cnt;
    case (w_cur_state)
      ST_IDLE: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = {CNT_W{1'b0}};
      end
      ST_SYNC: begin
        w_bit   = w_sync_sh[SYNC_W-1];
        w_valid = 1'b1;
        if (w_cur_cnt == SYNC_LAST) begin
          w_nxt_state = ST_DATA;
          w_nxt_cnt   = {CNT_W{1'b0}};
        end else begin
          w_nxt_state = ST_SYNC;
          w_nxt_cnt   = w_cur_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        w_bit   = w_msb;
        w_valid = 1'b1;
        w_shift = 1'b1;
        if (w_cur_cnt == DATA_LAST) begin
          w_nxt_cnt = {CNT_W{1'b0}};
`ifdef SEQ_TX_PARITY_EN
          w_nxt_state = ST_PAR;
`else
          w_done = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_nxt_state = ST_GAP;
          end else begin
            w_nxt_state = ST_IDLE;
          end
`endif
        end else begin
          w_nxt_state = ST_DATA;
          w_nxt_cnt   = w_cur_cnt + CNT_W'(1);
        end
      end
      ST_PAR: begin
`ifdef SEQ_TX_PARITY_EN
        w_bit = r_par;
`else
        w_bit = 1'b0;
`endif
        w_valid   = 1'b1;
        w_done    = 1'b1;
        w_nxt_cnt = {CNT_W{1'b0}};
        if (GAP_CYCLES > 0) begin
          w_nxt_state = ST_GAP;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (w_cur_cnt == GAP_LAST) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = {CNT_W{1'b0}};
        end else begin
          w_nxt_state = ST_GAP;
          w_nxt_cnt   = w_cur_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_out_bit    <= w_bit;
      r_out_valid  <= w_valid;
      r_frame_done <= w_done;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_bit    = r_out_bit;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

endmodule
